// File: rtl/rr_audio_pkg.sv
// Shared audio definitions: fade FSM encoding, default mixer/fade settings,
// and the note/octave constants used by the music tone generators.
package rr_audio_pkg;

  // Fade controller states; the encoding is visible on the fade_state port.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_FADE = 2'd2,
    ST_HOLD = 2'd3
  } fade_state_t;

  // Default channel amplitudes and fade shape.
  localparam logic [7:0] DEF_VOL_BASS   = 8'd96;
  localparam logic [7:0] DEF_VOL_MELODY = 8'd128;
  localparam logic [7:0] DEF_FADE_STEP  = 8'd8;
  localparam logic [7:0] DEF_GAIN_FLOOR = 8'd64;
  localparam logic [7:0] GAIN_FULL      = 8'd255;

  // Note indices within an octave, used by the music path to select tones.
  localparam logic [3:0] NOTE_C  = 4'd0;
  localparam logic [3:0] NOTE_CS = 4'd1;
  localparam logic [3:0] NOTE_D  = 4'd2;
  localparam logic [3:0] NOTE_DS = 4'd3;
  localparam logic [3:0] NOTE_E  = 4'd4;
  localparam logic [3:0] NOTE_F  = 4'd5;
  localparam logic [3:0] NOTE_FS = 4'd6;
  localparam logic [3:0] NOTE_G  = 4'd7;
  localparam logic [3:0] NOTE_GS = 4'd8;
  localparam logic [3:0] NOTE_A  = 4'd9;
  localparam logic [3:0] NOTE_AS = 4'd10;
  localparam logic [3:0] NOTE_B  = 4'd11;

  // Octave selectors: bass sits two octaves below the melody.
  localparam logic [2:0] OCTAVE_BASS   = 3'd2;
  localparam logic [2:0] OCTAVE_MELODY = 3'd4;

  // Saturating 9-bit -> 8-bit clamp used by the mixer.
  function automatic logic [7:0] sat8(input logic [8:0] v);
    return v[8] ? 8'hFF : v[7:0];
  endfunction

endpackage

// File: rtl/audio_mixer_pwm_if.sv
// Signal bundle for the audio mixer: game/tempo controls and speaker square
// waves in, PWM pin, applied duty level and fade state out.
// There is no valid/ready handshake here: speaker_b/speaker_m are levels that
// are sampled every cycle, and bpm_tick is a single-cycle strobe that is only
// meaningful on the cycle it is high (no backpressure, no acknowledge).
interface audio_mixer_pwm_if;
  logic       started;
  logic       loser;
  logic       bpm_tick;
  logic       speaker_b;
  logic       speaker_m;
  logic       audio_pwm;
  logic [7:0] level;
  logic [1:0] fade_state;

  // Side that drives the game controls and observes the audio outputs.
  modport master (
    output started, loser, bpm_tick, speaker_b, speaker_m,
    input  audio_pwm, level, fade_state
  );

  // Mixer side.
  modport slave (
    input  started, loser, bpm_tick, speaker_b, speaker_m,
    output audio_pwm, level, fade_state
  );
endinterface

// File: rtl/pwm_dac.sv
// 8-bit PWM DAC: free-running counter, level latched only at counter wrap so
// each 256-cycle period uses one duty value, registered compare output.
module pwm_dac (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] sample,
  output logic [7:0] level,
  output logic       pwm
);

  logic [7:0] r_cnt;
  logic [7:0] r_level;
  logic       r_pwm;
  logic [7:0] w_level_nxt;

  // The compare uses the level that will apply this period, so the duty
  // change lines up exactly with the counter==0 boundary.
  assign w_level_nxt = (r_cnt == 8'd0) ? sample : r_level;

  // Counter, period-latched level and registered compare.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt   <= 8'd0;
      r_level <= 8'd0;
      r_pwm   <= 1'b0;
    end else begin
      r_cnt   <= r_cnt + 8'd1;
      r_level <= w_level_nxt;
      r_pwm   <= (r_cnt < w_level_nxt);
    end
  end

  assign level = r_level;
  assign pwm   = r_pwm;

endmodule

// File: rtl/audio_mixer_pwm.sv
// Two-channel audio mixer with game-state fade: speakers -> register ->
// saturated mix -> gain scale -> PWM DAC. The fade FSM owns the gain.
module audio_mixer_pwm
  import rr_audio_pkg::*;
#(
  parameter logic [7:0] VOL_BASS   = DEF_VOL_BASS,
  parameter logic [7:0] VOL_MELODY = DEF_VOL_MELODY,
  parameter logic [7:0] FADE_STEP  = DEF_FADE_STEP,
  parameter logic [7:0] GAIN_FLOOR = DEF_GAIN_FLOOR
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       started,
  input  logic       loser,
  input  logic       bpm_tick,
  input  logic       speaker_b,
  input  logic       speaker_m,
  output logic       audio_pwm,
  output logic [7:0] level,
  output logic [1:0] fade_state
);

  logic        r_spk_b;
  logic        r_spk_m;
  logic [7:0]  r_mix;
  logic [7:0]  r_scaled;
  logic [7:0]  r_gain;
  fade_state_t r_state;

  fade_state_t w_state_nxt;
  logic [7:0]  w_gain_nxt;
  logic [8:0]  w_sum;
  logic [7:0]  w_scaled;
  logic [8:0]  w_dec;
  logic [7:0]  w_dec_gain;

  // Mix in 9 bits so bass+melody can never wrap before the clamp.
  assign w_sum = (r_spk_b ? {1'b0, VOL_BASS}   : 9'd0)
               + (r_spk_m ? {1'b0, VOL_MELODY} : 9'd0);

  // Keep only the upper byte of mix*gain (divide by 256).
  assign w_scaled = 8'((16'(r_mix) * 16'(r_gain)) >> 8);

  // 9-bit decrement: bit 8 set means the step went below zero.
  assign w_dec      = {1'b0, r_gain} - {1'b0, FADE_STEP};
  assign w_dec_gain = (w_dec[8] || (w_dec < {1'b0, GAIN_FLOOR})) ? GAIN_FLOOR : w_dec[7:0];

  // Three-stage audio pipeline: speaker sample, clamped mix, gain scale.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_spk_b  <= 1'b0;
      r_spk_m  <= 1'b0;
      r_mix    <= 8'd0;
      r_scaled <= 8'd0;
    end else begin
      r_spk_b  <= speaker_b;
      r_spk_m  <= speaker_m;
      r_mix    <= sat8(w_sum);
      r_scaled <= w_scaled;
    end
  end

  // Fade FSM state and gain registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_gain  <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_gain  <= w_gain_nxt;
    end
  end

  // Next state and gain; losing 'started' overrides every other transition.
  always_comb begin
    w_state_nxt = r_state;
    w_gain_nxt  = r_gain;
    if (!started) begin
      w_state_nxt = ST_IDLE;
      w_gain_nxt  = 8'd0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt = loser ? ST_FADE : ST_PLAY;
          w_gain_nxt  = GAIN_FULL;
        end
        ST_PLAY: begin
          // Gain stays full on the cycle FADE is entered, so a tick here is ignored.
          w_gain_nxt = GAIN_FULL;
          if (loser) w_state_nxt = ST_FADE;
        end
        ST_FADE: begin
          if (!loser) begin
            w_state_nxt = ST_PLAY;
            w_gain_nxt  = GAIN_FULL;
          end else if (r_gain <= GAIN_FLOOR) begin
            w_state_nxt = ST_HOLD;
            w_gain_nxt  = GAIN_FLOOR;
          end else if (bpm_tick) begin
            w_gain_nxt = w_dec_gain;
          end
        end
        ST_HOLD: begin
          if (!loser) begin
            w_state_nxt = ST_PLAY;
            w_gain_nxt  = GAIN_FULL;
          end else begin
            w_gain_nxt = GAIN_FLOOR;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_gain_nxt  = 8'd0;
        end
      endcase
    end
  end

  assign fade_state = r_state;

  pwm_dac u_pwm_dac (
    .clock  (clock),
    .reset  (reset),
    .sample (r_scaled),
    .level  (level),
    .pwm    (audio_pwm)
  );

endmodule

// File: tb/tb_audio_mixer_pwm.sv
// Directed bench for audio_mixer_pwm with hand-computed levels and duty counts.
module tb_audio_mixer_pwm;
  import rr_audio_pkg::*;

  // Clock and reset.
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  audio_mixer_pwm_if bus ();

  audio_mixer_pwm dut (
    .clock      (clock),
    .reset      (reset),
    .started    (bus.started),
    .loser      (bus.loser),
    .bpm_tick   (bus.bpm_tick),
    .speaker_b  (bus.speaker_b),
    .speaker_m  (bus.speaker_m),
    .audio_pwm  (bus.audio_pwm),
    .level      (bus.level),
    .fade_state (bus.fade_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Scoreboard: expected fade_state after each tempo tick.
  logic [1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Driver tasks.
  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_level(input logic [7:0] want, input string tag);
    int t;
    t = 0;
    while (bus.level !== want && t < 700) begin
      @(negedge clock);
      t++;
    end
    check(tag, bus.level, want);
  endtask

  task automatic count_high(output int n);
    n = 0;
    repeat (256) begin
      @(negedge clock);
      if (bus.audio_pwm === 1'b1) n++;
    end
  endtask

  task automatic tick;
    bus.bpm_tick = 1'b1;
    @(negedge clock);
    bus.bpm_tick = 1'b0;
  endtask

  // Watchdog.
  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    logic [7:0] lvl_or;
    int gain_m;

    reset         = 1'b0;
    bus.started   = 1'b0;
    bus.loser     = 1'b0;
    bus.bpm_tick  = 1'b0;
    bus.speaker_b = 1'b1;
    bus.speaker_m = 1'b1;

    #17;
    check("rst_level", bus.level, 0);
    check("rst_pwm", bus.audio_pwm, 0);
    check("rst_state", bus.fade_state, 0);

    @(negedge clock);
    reset = 1'b1;

    // Not started: silent for 1000 cycles even with both speakers on.
    hi = 0;
    lvl_or = 8'd0;
    repeat (1000) begin
      @(negedge clock);
      if (bus.audio_pwm === 1'b1) hi++;
      lvl_or = lvl_or | bus.level;
    end
    check("idle_level", lvl_or, 0);
    check("idle_pwm_high", hi, 0);
    check("idle_state", bus.fade_state, 0);

    // Play: mix 224, gain 255 -> 224*255/256 = 223.
    bus.started = 1'b1;
    @(negedge clock);
    check("play_state", bus.fade_state, 1);
    wait_level(8'd223, "play_level");
    count_high(hi);
    check("play_duty", hi, 223);

    // Lose with a tick on the entry cycle: that tick must not decrement.
    bus.loser = 1'b1;
    tick();
    check("fade_entry", bus.fade_state, 2);
    gain_m = 255;
    for (int k = 1; k <= 24; k++) begin
      gain_m = gain_m - 8;
      if (gain_m < 64) gain_m = 64;
      exp_q.push_back((gain_m == 64) ? 2'd3 : 2'd2);
    end
    cycles(15);
    for (int k = 1; k <= 24; k++) begin
      tick();
      cycles(15);
      check($sformatf("tick%0d_state", k), bus.fade_state, exp_q.pop_front());
    end
    // Floor gain 64: 224*64/256 = 56.
    wait_level(8'd56, "hold_level");
    tick();
    cycles(3);
    check("hold_stays", bus.fade_state, 3);

    // Recover from HOLD.
    bus.loser = 1'b0;
    @(negedge clock);
    check("resume_state", bus.fade_state, 1);
    wait_level(8'd223, "resume_level");

    // Melody only: 128*255/256 = 127.
    bus.speaker_b = 1'b0;
    wait_level(8'd127, "melody_level");
    count_high(hi);
    check("melody_duty", hi, 127);

    // Drop started mid-period: IDLE next cycle, level holds until wrap.
    cycles(37);
    bus.started = 1'b0;
    @(negedge clock);
    check("stop_state", bus.fade_state, 0);
    check("stop_hold", bus.level, 127);
    wait_level(8'd0, "stop_level");
    count_high(hi);
    check("stop_duty", hi, 0);

    // Start already lost: IDLE -> FADE directly at full gain.
    bus.speaker_b = 1'b1;
    bus.started   = 1'b1;
    bus.loser     = 1'b1;
    @(negedge clock);
    check("idle_to_fade", bus.fade_state, 2);
    cycles(4);
    repeat (3) begin
      tick();
      cycles(7);
    end
    // Gain 231: 224*231/256 = 202.
    wait_level(8'd202, "fade3_level");

    // Asynchronous reset mid-cycle with a tick pending.
    @(posedge clock);
    bus.bpm_tick = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    check("arst_level", bus.level, 0);
    check("arst_pwm", bus.audio_pwm, 0);
    check("arst_state", bus.fade_state, 0);
    @(negedge clock);
    bus.bpm_tick = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    check("post_rst_state", bus.fade_state, 2);
    check("post_rst_level", bus.level, 0);
    // Gain restarts at 255 with no decrement: level 223 again.
    wait_level(8'd223, "post_rst_full");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
